// File: rtl/sobol_bsg_if.sv
// Operand handshake, RNG control and unary-stream signals shared by sobol_bsg
// and its environment.
interface sobol_bsg_if #(
  parameter int BITWIDTH = 8
);
  logic                iEn;
  logic                iValid;
  logic                oReady;
  logic [BITWIDTH-1:0] iData;
  logic [BITWIDTH-1:0] iSobol;
  logic                oRngEn;
  logic                oRngClr;
  logic                oBit;
  logic                oBitValid;
  logic                oDone;
  logic [BITWIDTH-1:0] oOnes;

  modport slave (
    input  iEn, iValid, iData, iSobol,
    output oReady, oRngEn, oRngClr, oBit, oBitValid, oDone, oOnes
  );

  modport master (
    output iEn, iValid, iData, iSobol,
    input  oReady, oRngEn, oRngClr, oBit, oBitValid, oDone, oOnes
  );
endinterface

// File: rtl/sobol_bsg.sv
// Unary bitstream generator: steps a paired Sobol RNG through one full period
// and emits (operand > sample) each enabled cycle, so the ones-count equals the operand.
module sobol_bsg #(
  parameter int BITWIDTH = 8
) (
  input  logic         iClk,
  input  logic         iRstN,
  sobol_bsg_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [BITWIDTH-1:0] ONE = {{(BITWIDTH-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [BITWIDTH-1:0] operand_q, operand_d;
  logic [BITWIDTH-1:0] count_q, count_d;
  logic [BITWIDTH-1:0] ones_q, ones_d;
  logic                bit_q, bit_d;
  logic                bit_valid_q, bit_valid_d;
  logic                run_en;

  // The only combinational input-to-output path: iEn gates the RNG in RUN.
  assign run_en = (state_q == RUN) && bus.iEn;

  always_comb begin
    state_d     = state_q;
    operand_d   = operand_q;
    count_d     = count_q;
    ones_d      = ones_q;
    bit_d       = bit_q;
    bit_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.iValid) begin
          operand_d = bus.iData;
          ones_d    = '0;
          count_d   = '0;
          state_d   = CLR;
        end
      end
      CLR: begin
        state_d = RUN;
      end
      RUN: begin
        if (bus.iEn) begin
          bit_d       = (operand_q > bus.iSobol);
          bit_valid_d = 1'b1;
          ones_d      = ones_q + {{(BITWIDTH-1){1'b0}}, bit_d};
          count_d     = count_q + ONE;
          // Counter wraps back to zero here; it is reloaded on the next accept anyway.
          if (&count_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state_q     <= IDLE;
      operand_q   <= '0;
      count_q     <= '0;
      ones_q      <= '0;
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      operand_q   <= operand_d;
      count_q     <= count_d;
      ones_q      <= ones_d;
      bit_q       <= bit_d;
      bit_valid_q <= bit_valid_d;
    end
  end

  assign bus.oReady    = (state_q == IDLE);
  assign bus.oRngClr   = (state_q == CLR);
  assign bus.oRngEn    = run_en;
  assign bus.oDone     = (state_q == DONE);
  assign bus.oBit      = bit_q;
  assign bus.oBitValid = bit_valid_q;
  assign bus.oOnes     = ones_q;

endmodule

// File: tb/tb_sobol_bsg.sv
// Directed bench for sobol_bsg with a bit-reversal (first Sobol dimension) RNG
// stand-in and a queue of expected stream bits.
module tb_sobol_bsg;

  localparam int BW = 8;
  localparam int N  = 1 << BW;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  logic        exp_q[$];
  logic [BW-1:0] rng_idx = '0;

  sobol_bsg_if #(.BITWIDTH(BW)) bus ();

  sobol_bsg #(.BITWIDTH(BW)) dut (
    .iClk  (clk),
    .iRstN (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BW-1:0] bitrev(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    for (int i = 0; i < BW; i++) r[i] = v[BW-1-i];
    return r;
  endfunction

  // RNG stand-in: clear to element 0, advance one element per enabled edge.
  always @(posedge clk) begin
    if (bus.oRngClr) rng_idx <= '0;
    else if (bus.oRngEn) rng_idx <= rng_idx + 1'b1;
  end
  assign bus.iSobol = bitrev(rng_idx);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Entered at a negedge in IDLE; leaves at the negedge of the following IDLE cycle.
  task automatic run_stream(input logic [BW-1:0] operand, input int n_stall,
                            input bit hold_next, input logic [BW-1:0] next_op);
    bit          stall_map[0:299];
    int          cycles;
    int          enabled;
    int          picked;
    int          k;
    logic [BW-1:0] exp_ones;
    logic        b;

    for (int i = 0; i < 300; i++) stall_map[i] = 1'b0;
    picked = 0;
    while (picked < n_stall) begin
      k = $urandom_range(0, N + n_stall - 1);
      if (!stall_map[k]) begin
        stall_map[k] = 1'b1;
        picked++;
      end
    end

    exp_q.delete();
    exp_ones = '0;
    for (int i = 0; i < N; i++) begin
      b = (operand > bitrev(i[BW-1:0]));
      exp_q.push_back(b);
      exp_ones = exp_ones + {{(BW-1){1'b0}}, b};
    end

    bus.iValid = 1'b1;
    bus.iData  = operand;
    bus.iEn    = 1'b1;
    @(negedge clk);
    check("clr_pulse", bus.oRngClr, 1);
    check("clr_rngen", bus.oRngEn, 0);
    check("clr_ready", bus.oReady, 0);
    if (hold_next) bus.iData = next_op;
    else bus.iValid = 1'b0;

    @(negedge clk);
    check("run_first_valid", bus.oBitValid, 0);
    cycles  = 0;
    enabled = 0;
    while (enabled < N && cycles < 600) begin
      bus.iEn = (cycles < 300 && stall_map[cycles]) ? 1'b0 : 1'b1;
      #1;
      check("run_rngen", bus.oRngEn, bus.iEn);
      check("run_ready", bus.oReady, 0);
      check("run_clr", bus.oRngClr, 0);
      check("run_done", bus.oDone, 0);
      @(negedge clk);
      cycles++;
      if (bus.iEn) begin
        enabled++;
        check("bit_valid", bus.oBitValid, 1);
        check($sformatf("bit[%0d]", enabled - 1), bus.oBit, exp_q.pop_front());
      end else begin
        check("stall_gap", bus.oBitValid, 0);
      end
    end
    if (enabled < N) check("run_timeout", enabled, N);

    bus.iEn = 1'b1;
    #1;
    check("done_pulse", bus.oDone, 1);
    check("done_last_valid", bus.oBitValid, 1);
    check("done_rngen", bus.oRngEn, 0);
    check("done_ready", bus.oReady, 0);
    check("done_ones", bus.oOnes, exp_ones);
    check("run_cycles", cycles, N + n_stall);

    @(negedge clk);
    check("idle_ready", bus.oReady, 1);
    check("idle_done", bus.oDone, 0);
    check("idle_valid", bus.oBitValid, 0);
    check("idle_ones_hold", bus.oOnes, exp_ones);
    $display("stream operand=%0d stalls=%0d ones=%0d run_cycles=%0d", operand, n_stall, bus.oOnes, cycles);
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.iValid = 1'b0;
    bus.iEn    = 1'b0;
    bus.iData  = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", bus.oReady, 1);
    check("rst_valid", bus.oBitValid, 0);
    check("rst_done", bus.oDone, 0);
    check("rst_ones", bus.oOnes, 0);
    check("rst_rngen", bus.oRngEn, 0);
    check("rst_rngclr", bus.oRngClr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_stream(8'd100, 0, 1'b0, 8'd0);
    run_stream(8'd0,   0, 1'b0, 8'd0);
    run_stream(8'd255, 0, 1'b0, 8'd0);
    run_stream(8'd37, 10, 1'b0, 8'd0);

    // Second operand held valid through the whole first stream.
    run_stream(8'd200, 0, 1'b1, 8'd5);
    run_stream(8'd5,   0, 1'b0, 8'd0);

    // Reset at stream cycle 50 discards the partial stream.
    bus.iValid = 1'b1;
    bus.iData  = 8'd150;
    bus.iEn    = 1'b1;
    @(negedge clk);
    bus.iValid = 1'b0;
    repeat (50) @(negedge clk);
    check("midrun_ones_nonzero", (bus.oOnes != 0), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrun_rst_ready", bus.oReady, 1);
    check("midrun_rst_valid", bus.oBitValid, 0);
    check("midrun_rst_done", bus.oDone, 0);
    check("midrun_rst_ones", bus.oOnes, 0);
    check("midrun_rst_rngen", bus.oRngEn, 0);
    rst_n = 1'b1;
    $display("reset mid-RUN at stream cycle 50 ones=%0d", bus.oOnes);
    run_stream(8'd64, 0, 1'b0, 8'd0);

    // Reset while in CLR, valid held high across it.
    bus.iValid = 1'b1;
    bus.iData  = 8'd77;
    @(negedge clk);
    check("clrrst_in_clr", bus.oRngClr, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("clrrst_ready", bus.oReady, 1);
    check("clrrst_no_accept", bus.oRngClr, 0);
    rst_n = 1'b1;
    $display("reset in CLR with valid held, ready=%0d", bus.oReady);
    run_stream(8'd77, 0, 1'b0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
